sram_like_responder: RTL
========================

# sram_like_responder

Responder (slave) end of the team's SRAM-like request/response interface: it accepts `req`/`addr_ok` address-phase handshakes, queues them in order, and returns one `data_ok` per accepted request after a fixed service delay, backed by an internal word-addressed memory. It sits opposite the CPU's instruction or data port and is used as the memory model for core bring-up, and as the template for later bridge slaves. Responses are strictly in order and never back-pressured.

## Interface
- `ADDR_W`, 12: memory index width in words (memory holds 2^ADDR_W 32-bit words).
- `DEPTH`, 4: outstanding-request queue depth; power of two, ≥2.
- `RESP_DELAY`, 1: cycles from a request reaching queue head to its `data_ok`; range 1..15.
- `clk`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  reset; asynchronous, active-low.
- `req`  in  1  initiator request valid.
- `wr`  in  1  1 = write, 0 = read.
- `size`  in  2  0 byte, 1 half, 2 word; recorded, not used for addressing.
- `wstrb`  in  4  byte enables for writes; ignored for reads.
- `addr`  in  32  byte address; word index = `addr[ADDR_W+1:2]`, upper bits and `addr[1:0]` ignored.
- `wdata`  in  32  write data.
- `addr_ok`  out  1  request accepted this cycle when `req & addr_ok`.
- `data_ok`  out  1  one-cycle pulse completing the oldest outstanding request (read or write).
- `rdata`  out  32  read data, valid only while `data_ok` for a read; 0 otherwise.

## Operation
- `addr_ok = !full`; depends only on registered state, never on `req` (no combinational loop with initiator).
- Accept: on `req & addr_ok`, push {wr, size, wstrb, index, wdata} into the queue.
- Head service: counter `cnt` cleared whenever a new entry becomes head (push into empty queue, or pop with a following entry); increments while head valid; `data_ok = head_valid & (cnt == RESP_DELAY-1)`.
- Completion cycle (`data_ok`=1): pop head; if write, commit `wdata` bytes where `wstrb` set to `mem[index]`; if read, `rdata = mem[index]` (combinational from array at head index).
- Write with `wstrb=0`: no memory change, still completes with `data_ok`.
- Read-after-write ordering: the write commits at its own completion edge, so any later read observes it.
- Push and pop in the same cycle allowed when not full; count unchanged. When full, no push even if a pop happens that cycle (`addr_ok` stays 0 that cycle).
- Initiator must accept `data_ok` unconditionally; no stall input exists.

## Timing
- Reset values: `addr_ok`=1 once queue empty (immediately in reset), `data_ok`=0, `rdata`=0, queue empty, `cnt`=0. Memory array not reset.
- Latency: request accepted in cycle T into empty queue → `data_ok` in cycle T+RESP_DELAY.
- Throughput: one completion per RESP_DELAY cycles; RESP_DELAY=1 gives one per cycle back-to-back.
- Full: after DEPTH accepts with no completion, `addr_ok` drops the next cycle; rises the cycle after a pop.
- Reset mid-operation: all outstanding requests discarded, no `data_ok` for them; uncommitted writes lost; committed memory contents retained.
- Pointer wrap-around at DEPTH handled with one extra pointer bit for full/empty discrimination.

## Structure
- Shared package `sram_like_pkg`: size encodings (`SZ_BYTE/SZ_HALF/SZ_WORD`), request-entry struct typedef (wr, size, wstrb, index, wdata).
- Sub-module `sram_like_req_fifo`: parameterised synchronous FIFO (DEPTH, entry width) with full/empty, async active-low reset on pointers only.
- Top holds head counter, memory array, write-commit logic, output muxing.

## Test plan
- Single write then read, RESP_DELAY=1: write 0xDEADBEEF to 0x100 accepted at T → `data_ok` at T+1; read 0x100 → `data_ok` with `rdata`=0xDEADBEEF.
- Byte strobe: word 0x11223344 at 0x40, then write 0xAABBCCDD with `wstrb`=4'b0101 → read returns 0x11BB33DD; `wstrb`=0 write leaves it unchanged but still gets `data_ok`.
- Back-pressure: DEPTH=4, RESP_DELAY=8, `req` held high → exactly 4 accepts, `addr_ok`=0 until first `data_ok`, then one more accept; completions in issue order, 8 cycles apart.
- Back-to-back read-after-write: RESP_DELAY=1, write 0x5 to 0x8 and read 0x8 in consecutive cycles → read returns 0x5, two `data_ok` in consecutive cycles.
- Reset mid-operation: 3 requests outstanding, pulse `resetn` low asynchronously → no `data_ok` afterwards, `addr_ok`=1, previously completed writes still readable.

Source files
------------

// File: rtl/sram_like_pkg.sv
// Shared types for the SRAM-like request/response responder: size codes,
// the queued request entry, and the byte-strobe merge helper.
package sram_like_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Widest word index a 32-bit byte address can carry; the top keeps only ADDR_W bits.
    localparam int IDX_W = 30;

    typedef struct packed {
        logic             wr;
        logic [1:0]       size;
        logic [3:0]       wstrb;
        logic [IDX_W-1:0] index;
        logic [31:0]      wdata;
    } req_entry_t;

    localparam int ENTRY_W = $bits(req_entry_t);

    // Replace the bytes of old_w selected by strb with the matching bytes of new_w.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_like_req_fifo.sv
// In-order request queue. Pointers carry one extra bit so a wrapped write
// pointer can be told apart from an empty queue. Storage is not reset.
module sram_like_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] store_q [DEPTH];
    logic         do_push_s;
    logic         do_pop_s;

    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign dout  = store_q[rd_ptr_q[PW-1:0]];

    // Next pointer values; a push while full or a pop while empty is ignored.
    always_comb begin
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers, cleared by reset so the queue restarts empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            store_q[wr_ptr_q[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like interface: queues accepted requests in order,
// completes the head after RESP_DELAY cycles, and backs them with a word memory.
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DEPTH      = 4,
    parameter int RESP_DELAY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int         MEM_WORDS = 1 << ADDR_W;
    localparam logic [3:0] CNT_LAST  = 4'(RESP_DELAY - 1);

    req_entry_t          push_entry_s;
    req_entry_t          head_s;
    logic [ENTRY_W-1:0]  head_bits_s;
    logic                full_s;
    logic                empty_s;
    logic                push_s;
    logic                pop_s;
    logic                head_valid_s;
    logic [ADDR_W-1:0]   head_idx_s;
    logic [3:0]          cnt_q, cnt_d;
    logic                mem_we_s;
    logic [31:0]         mem_wdata_d;
    logic [31:0]         mem_q [MEM_WORDS];
    logic                unused_bits_s;

    // addr_ok comes from registered queue state only, never from req.
    assign addr_ok      = ~full_s;
    assign push_s       = req & addr_ok;
    assign head_valid_s = ~empty_s;
    assign head_s       = head_bits_s;
    assign head_idx_s   = head_s.index[ADDR_W-1:0];
    assign data_ok      = head_valid_s && (cnt_q == CNT_LAST);
    assign pop_s        = data_ok;

    // Byte offset, high address bits and the recorded size do not affect addressing.
    assign unused_bits_s = ^{addr[31:ADDR_W+2], addr[1:0], head_s.size,
                             head_s.index[IDX_W-1:ADDR_W]};

    // Pack the incoming request into a queue entry.
    always_comb begin
        push_entry_s       = '0;
        push_entry_s.wr    = wr;
        push_entry_s.size  = size;
        push_entry_s.wstrb = wstrb;
        push_entry_s.index = IDX_W'(addr[ADDR_W+1:2]);
        push_entry_s.wdata = wdata;
    end

    sram_like_req_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_req_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_entry_s),
        .dout  (head_bits_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Head service counter: restarts for every new head, counts while a head waits.
    always_comb begin
        cnt_d = cnt_q;
        if (pop_s) begin
            cnt_d = 4'd0;
        end else if (head_valid_s) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = 4'd0;
        end
    end

    // Service counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Write commit value: a completing write merges its strobed bytes into the word.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_wdata_d = mem_q[head_idx_s];
        if (pop_s && head_s.wr) begin
            mem_we_s    = 1'b1;
            mem_wdata_d = merge_bytes(mem_q[head_idx_s], head_s.wdata, head_s.wstrb);
        end else begin
            mem_we_s    = 1'b0;
            mem_wdata_d = mem_q[head_idx_s];
        end
    end

    // Memory array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[head_idx_s] <= mem_wdata_d;
        end
    end

    // Read data is driven only during a read completion, zero otherwise.
    always_comb begin
        rdata = 32'h0000_0000;
        if (data_ok && !head_s.wr) begin
            rdata = mem_q[head_idx_s];
        end else begin
            rdata = 32'h0000_0000;
        end
    end

endmodule
